// File: rtl/fir_prog_filter.sv
// ---------------------------------------------------------------------------
// fir_prog_filter
//
// Pipelined N_TAPS-tap FIR filter with run-time programmable coefficients.
// Sits between a sample source (decimator / ADC front end) and downstream
// slicing logic.
//
// Datapath (each stage advances only while i_en=1):
//   delay line : shifts in i_is_data when i_en & i_valid
//   S1         : N_TAPS registered products active[k] * tap[k]
//   S2         : registered full-precision sum (cannot overflow)
//   S3         : rounded / saturated output word, o_valid, o_sat
// A sample accepted at edge n appears on o_os_data/o_valid after edge n+3;
// stalled edges (i_en=0) add latency one-for-one.
//
// Handshake: valid-only. A sample is taken on every rising edge where
// i_en & i_valid; there is no back-pressure. o_valid marks the edge on which
// o_os_data/o_sat carry a new result; with o_valid=0 o_os_data keeps its last
// value and o_sat is meaningless.
//
// Coefficients are double-buffered: i_coeff_we writes the shadow bank only,
// i_coeff_commit copies the whole shadow bank into the active bank in one
// edge. A write and a commit on the same edge commit the pre-edge shadow.
//
// Build option:
//   FIR_ROUND_EN  defined   -> round-half-up before dropping fraction bits
//                 undefined -> truncation (floor)
//
// Ports:
//   clk            system clock, rising edge
//   i_srst         synchronous active-high reset (wins over everything)
//   i_en           global enable; 0 freezes delay line, pipeline, outputs
//   i_is_data      signed input sample
//   i_valid        i_is_data qualifier
//   i_coeff_we     shadow coefficient write strobe
//   i_coeff_addr   shadow tap index (writes with addr >= N_TAPS ignored)
//   i_coeff_data   signed coefficient
//   i_coeff_commit copy shadow bank to active bank
//   o_os_data      signed filtered sample
//   o_valid        o_os_data qualifier
//   o_sat          set with an o_valid word that was saturated
// ---------------------------------------------------------------------------
module fir_prog_filter #(
  parameter int N_TAPS     = 4,
  parameter int NB_INPUT   = 8,
  parameter int NBF_INPUT  = 7,
  parameter int NB_COEFF   = 8,
  parameter int NBF_COEFF  = 7,
  parameter int NB_OUTPUT  = 8,
  parameter int NBF_OUTPUT = 7,
  localparam int ADDR_W    = (N_TAPS > 1) ? $clog2(N_TAPS) : 1
) (
  input  logic                        clk,
  input  logic                        i_srst,
  input  logic                        i_en,
  input  logic signed [NB_INPUT-1:0]  i_is_data,
  input  logic                        i_valid,
  input  logic                        i_coeff_we,
  input  logic        [ADDR_W-1:0]    i_coeff_addr,
  input  logic signed [NB_COEFF-1:0]  i_coeff_data,
  input  logic                        i_coeff_commit,
  output logic signed [NB_OUTPUT-1:0] o_os_data,
  output logic                        o_valid,
  output logic                        o_sat
);

  // -------------------------------------------------------------------------
  // Derived widths
  // -------------------------------------------------------------------------
  localparam int NB_PROD = NB_INPUT + NB_COEFF;
  localparam int NB_ADD  = NB_PROD + $clog2(N_TAPS);
  // Number of fractional LSBs dropped when forming the output word.
  localparam int D       = NBF_INPUT + NBF_COEFF - NBF_OUTPUT;

`ifdef FIR_ROUND_EN
  // One extra bit so adding the half-LSB can never wrap the sum.
  localparam int NB_RND  = NB_ADD + 1;
`else
  localparam int NB_RND  = NB_ADD;
`endif

  // Width of the value left after dropping D bits.
  localparam int NB_SH   = NB_RND - D;

  // Impulse set loaded at reset: tap0 = 2^(NB_COEFF-2), i.e. 0.5 in Q1.(NB_COEFF-1).
  localparam logic signed [NB_COEFF-1:0] IMPULSE = NB_COEFF'(1) <<< (NB_COEFF - 2);

  // -------------------------------------------------------------------------
  // Coefficient banks
  // -------------------------------------------------------------------------
  logic signed [NB_COEFF-1:0] shadow [N_TAPS];
  logic signed [NB_COEFF-1:0] active [N_TAPS];

  logic addr_ok;
  assign addr_ok = (int'(i_coeff_addr) < N_TAPS);

  // The commit reads shadow before this edge's write lands, so a same-edge
  // write only reaches the active bank at a later commit.
  always_ff @(posedge clk) begin
    if (i_srst) begin
      for (int k = 0; k < N_TAPS; k++) begin
        shadow[k] <= (k == 0) ? IMPULSE : '0;
        active[k] <= (k == 0) ? IMPULSE : '0;
      end
    end else begin
      if (i_coeff_commit) begin
        for (int k = 0; k < N_TAPS; k++) begin
          active[k] <= shadow[k];
        end
      end
      if (i_coeff_we && addr_ok) begin
        shadow[i_coeff_addr] <= i_coeff_data;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Delay line and pipeline registers
  // -------------------------------------------------------------------------
  logic signed [NB_INPUT-1:0] taps [N_TAPS];
  logic                       v0;           // delay line holds a new sample

  logic signed [NB_PROD-1:0]  prod   [N_TAPS];
  logic signed [NB_PROD-1:0]  prod_c [N_TAPS];
  logic                       v1;

  logic signed [NB_ADD-1:0]   sum;
  logic signed [NB_ADD-1:0]   sum_c;
  logic                       v2;

  // Products: operands are sign-extended to the full product width first so
  // the multiply is exact in NB_PROD bits.
  always_comb begin
    for (int k = 0; k < N_TAPS; k++) begin
      prod_c[k] = NB_PROD'(active[k]) * NB_PROD'(taps[k]);
    end
  end

  // Full-precision adder tree; clog2(N_TAPS) guard bits make overflow impossible.
  always_comb begin
    sum_c = '0;
    for (int k = 0; k < N_TAPS; k++) begin
      sum_c = sum_c + NB_ADD'(prod[k]);
    end
  end

  // -------------------------------------------------------------------------
  // Output conversion (combinational from the S2 sum, registered in S3)
  // -------------------------------------------------------------------------
  logic signed [NB_RND-1:0]    rnd;
  logic signed [NB_SH-1:0]     shd;
  logic signed [NB_OUTPUT-1:0] conv;
  logic                        sat_c;

`ifdef FIR_ROUND_EN
  localparam int RND_SH = (D > 0) ? (D - 1) : 0;
  localparam logic signed [NB_RND-1:0] RND_HALF =
    (D > 0) ? (NB_RND'(1) <<< RND_SH) : '0;

  always_comb begin
    rnd = NB_RND'(sum) + RND_HALF;
  end
`else
  always_comb begin
    rnd = sum;
  end
`endif

  // Arithmetic shift drops the D fractional LSBs (floor on the possibly
  // rounded value).
  assign shd = NB_SH'(rnd >>> D);

  generate
    if (NB_SH > NB_OUTPUT) begin : g_sat
      // Bits above the output sign bit, plus the sign bit itself: they must
      // all agree for the value to fit.
      logic [NB_SH-NB_OUTPUT:0] excess;
      logic                     fits;

      always_comb begin
        excess = shd[NB_SH-1:NB_OUTPUT-1];
        fits   = (&excess) | (~|excess);
        sat_c  = ~fits;
        if (fits) begin
          conv = shd[NB_OUTPUT-1:0];
        end else if (rnd[NB_RND-1]) begin
          conv = {1'b1, {(NB_OUTPUT-1){1'b0}}};
        end else begin
          conv = {1'b0, {(NB_OUTPUT-1){1'b1}}};
        end
      end
    end else begin : g_nosat
      // The output is at least as wide as the shifted sum: plain sign extend.
      always_comb begin
        conv  = NB_OUTPUT'(shd);
        sat_c = 1'b0;
      end
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Sequential datapath
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (i_srst) begin
      for (int k = 0; k < N_TAPS; k++) begin
        taps[k] <= '0;
        prod[k] <= '0;
      end
      v0        <= 1'b0;
      v1        <= 1'b0;
      sum       <= '0;
      v2        <= 1'b0;
      o_os_data <= '0;
      o_valid   <= 1'b0;
      o_sat     <= 1'b0;
    end else if (i_en) begin
      // Delay line moves only on an accepted sample.
      if (i_valid) begin
        taps[0] <= i_is_data;
        for (int k = 1; k < N_TAPS; k++) begin
          taps[k] <= taps[k-1];
        end
      end
      v0 <= i_valid;

      // S1: products from the pre-edge active bank.
      for (int k = 0; k < N_TAPS; k++) begin
        prod[k] <= prod_c[k];
      end
      v1 <= v0;

      // S2: full-precision sum.
      sum <= sum_c;
      v2  <= v1;

      // S3: output word only updates for valid results; bubbles hold it.
      o_valid <= v2;
      o_sat   <= v2 & sat_c;
      if (v2) begin
        o_os_data <= conv;
      end
    end
  end

endmodule
